// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake, 2-entry skid buffer,
// stall/flush control and saturating stall/flush event counters.
module pipe_stage_skid #(
    parameter int                WIDTH      = 64,
    parameter logic [WIDTH-1:0]  FLUSH_MASK = 64'h0000_0000_FFFF_FFFF,
    parameter logic [WIDTH-1:0]  NOP_VALUE  = '0,
    parameter int                CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    input  logic             stall,
    input  logic             flush,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);
    // Handshake: a beat moves on a port only in a cycle where valid and ready
    // are both 1 at the rising edge; both sides hold their signals stable
    // for the whole cycle.

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_main_data;
    logic [WIDTH-1:0] r_skid_data;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;
    logic             w_accept;
    logic             w_drain;

    // in_ready depends only on stored state and stall/rst, never on out_ready.
    always_comb begin
        in_ready  = (r_state != ST_FULL) & ~stall & ~rst;
        out_valid = (r_state != ST_EMPTY) & ~stall;
        occupancy = r_state;
    end

    assign w_accept  = in_valid & in_ready;
    assign w_drain   = out_valid & out_ready;
    assign out_data  = r_main_data;
    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;

    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: if (w_accept) w_state_nxt = ST_ONE;
                ST_ONE: begin
                    if (w_accept && !w_drain)      w_state_nxt = ST_FULL;
                    else if (!w_accept && w_drain) w_state_nxt = ST_EMPTY;
                end
                ST_FULL:  if (w_drain) w_state_nxt = ST_ONE;
                default:  w_state_nxt = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_EMPTY;
        else     r_state <= w_state_nxt;
    end

    // A flush keeps the unmasked fields (e.g. the PC) of the main entry visible.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_main_data <= '0;
            r_skid_data <= '0;
        end else if (flush) begin
            r_main_data <= (r_main_data & ~FLUSH_MASK) | (NOP_VALUE & FLUSH_MASK);
        end else begin
            case (r_state)
                ST_EMPTY: if (w_accept) r_main_data <= in_data;
                ST_ONE: begin
                    if (w_accept && w_drain) r_main_data <= in_data;
                    else if (w_accept)       r_skid_data <= in_data;
                end
                ST_FULL:  if (w_drain) r_main_data <= r_skid_data;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (flush && r_flush_cnt != CNT_MAX)
                r_flush_cnt <= r_flush_cnt + 1'b1;
            if (stall && !flush && r_stall_cnt != CNT_MAX)
                r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

endmodule
